// File: rtl/bitcoin_hash_multi.sv
// Nonce-search engine: double SHA-256 over an 80-byte header for a range of
// nonces, using NUM_CORES compression cores run in batches.
// Includes the single-block compression core simplified_sha256.

module simplified_sha256 (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] input_hash,
  input  logic [511:0] message,
  output logic         done,
  output logic [255:0] output_hash
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0]  w [16];
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] hin;
  logic [5:0]   t;
  logic [31:0]  t1, t2, w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // one round of compression plus the next message-schedule word
  always_comb begin
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[0];
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  // load on start, then 64 rounds one per cycle; done rises with the digest
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b1;
      t <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      hin <= '0;
      output_hash <= '0;
      for (int j = 0; j < 16; j++) w[j] <= '0;
    end else if (start) begin
      done <= 1'b0;
      t <= '0;
      {a, b, c, d, e, f, g, h} <= input_hash;
      hin <= input_hash;
      for (int j = 0; j < 16; j++) w[j] <= message[511-32*j -: 32];
    end else if (!done) begin
      {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
      for (int j = 0; j < 15; j++) w[j] <= w[j+1];
      w[15] <= w_new;
      t <= t + 6'd1;
      if (t == 6'd63) begin
        done <= 1'b1;
        output_hash <= {hin[255:224] + t1 + t2, hin[223:192] + a, hin[191:160] + b,
                        hin[159:128] + c, hin[127:96] + d + t1, hin[95:64] + e,
                        hin[63:32] + f, hin[31:0] + g};
      end
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for start, done high
// READ  | fetching header words 0..19
// BLK1  | core 0 hashes header words 0..15 into the midstate
// BLK2  | all cores hash the nonce block from the midstate
// BLK3  | all cores hash their first digest (second SHA-256)
// WRITE | dump H0 words, or scan the batch for a hit
// FINAL | search-mode result writes
module bitcoin_hash_multi #(
  parameter int NUM_NONCES = 16,
  parameter int NUM_CORES  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] nonce_base,
  input  logic        search_en,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CORES - 1);
  localparam logic [31:0]   LAST_OFF = 32'(NUM_NONCES - NUM_CORES);

  typedef enum logic [2:0] {IDLE, READ, BLK1, BLK2, BLK3, WRITE, FINAL} state_t;
  state_t state, state_nx;
  // phase within a BLK state: 0 pulse start, 1 wait for done low, 2 wait for done high
  logic [1:0] phase, phase_nx;

  logic [15:0]   msg_addr_q, out_addr_q;
  logic [31:0]   nonce_q, target_q;
  logic          search_q;
  logic [4:0]    cnt;
  logic [IW-1:0] idx;
  logic [31:0]   batch_off;
  logic [31:0]   hdr [20];
  logic [255:0]  midstate;
  logic [31:0]   h0 [NUM_CORES];
  logic [31:0]   found_h0;
  logic [511:0]  hdr_lo;

  logic [NUM_CORES-1:0] core_start, core_done;
  logic [255:0]         core_hash [NUM_CORES];
  logic                 cores_low, cores_high, last_batch, hit;
  logic [IW-1:0]        hit_idx;
  logic [31:0]          hit_h0;

  assign mem_clk    = clk;
  assign done       = (state == IDLE);
  assign last_batch = (batch_off == LAST_OFF);
  assign hdr_lo = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5], hdr[6], hdr[7],
                   hdr[8], hdr[9], hdr[10], hdr[11], hdr[12], hdr[13], hdr[14], hdr[15]};
  assign cores_low  = (state == BLK1) ? !core_done[0] : ~|core_done;
  assign cores_high = (state == BLK1) ?  core_done[0] :  &core_done;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic [31:0]  nonce;
    logic [255:0] hv;
    logic [511:0] blk;
    assign nonce = nonce_q + batch_off + 32'(i);
    // chaining value and block for this core in the current pass
    always_comb begin
      hv  = IV;
      blk = {hdr[16], hdr[17], hdr[18], nonce, 32'h8000_0000, 320'd0, 32'd640};
      if (state == BLK1) begin
        blk = hdr_lo;
      end else if (state == BLK2) begin
        hv = midstate;
      end else if (state == BLK3) begin
        blk = {core_hash[i], 32'h8000_0000, 192'd0, 32'd256};
      end
    end
    simplified_sha256 u_core (
      .clk(clk), .reset_n(reset_n), .start(core_start[i]),
      .input_hash(hv), .message(blk), .done(core_done[i]), .output_hash(core_hash[i])
    );
  end

  // lowest core index whose H0 is below target
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    hit_h0 = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (h0[i] < target_q) begin
        hit = 1'b1;
        hit_idx = IW'(i);
        hit_h0 = h0[i];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      phase <= 2'd0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
    end
  end

  // next state, core start pulses and memory port drive
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    core_start = '0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_write_data = '0;
    case (state)
      IDLE: if (start) state_nx = READ;
      READ: begin
        if (cnt < 5'd20) mem_addr = msg_addr_q + 16'(cnt);
        else state_nx = BLK1;
      end
      BLK1, BLK2, BLK3: begin
        case (phase)
          2'd0: begin
            core_start[0] = 1'b1;
            if (state != BLK1) core_start = '1;
            phase_nx = 2'd1;
          end
          2'd1: if (cores_low) phase_nx = 2'd2;
          default: if (cores_high) begin
            phase_nx = 2'd0;
            state_nx = (state == BLK1) ? BLK2 : (state == BLK2) ? BLK3 : WRITE;
          end
        endcase
      end
      WRITE: begin
        if (search_q) begin
          state_nx = (hit || last_batch) ? FINAL : BLK2;
        end else begin
          mem_we = 1'b1;
          mem_addr = out_addr_q + batch_off[15:0] + 16'(idx);
          mem_write_data = h0[idx];
          if (idx == LAST_IDX) state_nx = last_batch ? FINAL : BLK2;
        end
      end
      FINAL: begin
        if (search_q) begin
          mem_we = 1'b1;
          mem_addr = out_addr_q + 16'(idx);
          mem_write_data = !found ? 32'hFFFF_FFFF : (idx == '0) ? found_nonce : found_h0;
          if (idx == IW'(1)) state_nx = IDLE;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // run parameters, header capture, midstate/H0 capture, batch and hit tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_addr_q <= '0; out_addr_q <= '0; nonce_q <= '0; target_q <= '0; search_q <= 1'b0;
      cnt <= '0; idx <= '0; batch_off <= '0; midstate <= '0; found_h0 <= '0;
      found <= 1'b0; found_nonce <= '0;
      for (int j = 0; j < 20; j++) hdr[j] <= '0;
      for (int j = 0; j < NUM_CORES; j++) h0[j] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          msg_addr_q <= message_addr; out_addr_q <= output_addr; nonce_q <= nonce_base;
          target_q <= target; search_q <= search_en;
          found <= 1'b0; found_nonce <= '0;
          cnt <= '0; idx <= '0; batch_off <= '0;
        end
        READ: begin
          if (cnt != 5'd0) hdr[cnt - 5'd1] <= mem_read_data;
          cnt <= cnt + 5'd1;
        end
        BLK1: if (phase == 2'd2 && cores_high) midstate <= core_hash[0];
        BLK3: if (phase == 2'd2 && cores_high) begin
          for (int j = 0; j < NUM_CORES; j++) h0[j] <= core_hash[j][255:224];
          idx <= '0;
        end
        WRITE: begin
          if (search_q) begin
            idx <= '0;
            if (hit) begin
              found <= 1'b1;
              found_nonce <= nonce_q + batch_off + 32'(hit_idx);
              found_h0 <= hit_h0;
            end else if (!last_batch) begin
              batch_off <= batch_off + 32'(NUM_CORES);
            end
          end else if (idx == LAST_IDX) begin
            idx <= '0;
            if (!last_batch) batch_off <= batch_off + 32'(NUM_CORES);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FINAL: idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bitcoin_hash_multi.sv
// Directed bench for bitcoin_hash_multi with an independent SHA-256 model.
module tb_bitcoin_hash_multi;
  localparam logic [15:0] MSG = 16'h0100;
  localparam logic [15:0] OUT = 16'h0800;
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam int SW_NC [3] = '{1, 4, 16};

  logic clk, reset_n, start, search_en, done, found, mem_clk, mem_we;
  logic [15:0] message_addr, output_addr, mem_addr;
  logic [31:0] nonce_base, target, found_nonce, mem_write_data, mem_read_data;
  logic [31:0] mem [65536];
  logic [31:0] hdr_w [20];
  logic [15:0] rd_addr [20];
  logic        rd_we_seen;
  logic [15:0] wq_addr [$];
  logic [31:0] wq_data [$];
  logic        sw_start, sw_clr;
  logic [2:0]  sw_done;
  int tests, fails;

  bitcoin_hash_multi dut (
    .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr),
    .output_addr(output_addr), .nonce_base(nonce_base), .search_en(search_en), .target(target),
    .done(done), .found(found), .found_nonce(found_nonce), .mem_clk(mem_clk), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_write_data);
    end
  end

  for (genvar g = 0; g < 3; g++) begin : sw
    logic we, mclk, fnd, dn;
    logic [15:0] a;
    logic [31:0] wd, rd, fn;
    logic [31:0] img [16];
    int wr_cnt;
    bitcoin_hash_multi #(.NUM_NONCES(16), .NUM_CORES(SW_NC[g])) u (
      .clk(clk), .reset_n(reset_n), .start(sw_start), .message_addr(message_addr),
      .output_addr(output_addr), .nonce_base(nonce_base), .search_en(search_en), .target(target),
      .done(dn), .found(fnd), .found_nonce(fn), .mem_clk(mclk), .mem_we(we),
      .mem_addr(a), .mem_write_data(wd), .mem_read_data(rd)
    );
    assign sw_done[g] = dn;
    always @(posedge clk) begin
      rd <= mem[a];
      if (sw_clr) begin
        wr_cnt <= 0;
        for (int k = 0; k < 16; k++) img[k] <= 32'hDEAD_BEEF;
      end else if (we) begin
        wr_cnt <= wr_cnt + 1;
        if (a >= OUT && a < OUT + 16'd16) img[4'(a - OUT)] <= wd;
      end
    end
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hv, input logic [511:0] blk);
    logic [31:0] ws [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, ch, mj, x, y;
    logic [255:0] r;
    for (int j = 0; j < 16; j++) ws[j] = blk[511-32*j -: 32];
    for (int j = 16; j < 64; j++) begin
      s0 = ror(ws[j-15], 7) ^ ror(ws[j-15], 18) ^ (ws[j-15] >> 3);
      s1 = ror(ws[j-2], 17) ^ ror(ws[j-2], 19) ^ (ws[j-2] >> 10);
      ws[j] = ws[j-16] + s0 + ws[j-7] + s1;
    end
    for (int j = 0; j < 8; j++) v[j] = hv[255-32*j -: 32];
    for (int j = 0; j < 64; j++) begin
      s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
      ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
      x  = v[7] + s1 + ch + K[j] + ws[j];
      s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
      mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      y  = s0 + mj;
      for (int m = 7; m > 0; m--) v[m] = v[m-1];
      v[4] = v[4] + x;
      v[0] = x + y;
    end
    for (int j = 0; j < 8; j++) r[255-32*j -: 32] = hv[255-32*j -: 32] + v[j];
    return r;
  endfunction

  function automatic logic [31:0] golden_h0(input logic [31:0] nonce);
    logic [511:0] b1;
    logic [255:0] mid, d2, d3;
    for (int j = 0; j < 16; j++) b1[511-32*j -: 32] = hdr_w[j];
    mid = sha_compress(IV, b1);
    d2 = sha_compress(mid, {hdr_w[16], hdr_w[17], hdr_w[18], nonce, 32'h8000_0000, 320'd0, 32'd640});
    d3 = sha_compress(IV, {d2, 32'h8000_0000, 192'd0, 32'd256});
    return d3[255:224];
  endfunction

  function automatic logic [31:0] sw_img(input int g, input int k);
    case (g)
      0: return sw[0].img[k];
      1: return sw[1].img[k];
      default: return sw[2].img[k];
    endcase
  endfunction

  function automatic int sw_wr(input int g);
    case (g)
      0: return sw[0].wr_cnt;
      1: return sw[1].wr_cnt;
      default: return sw[2].wr_cnt;
    endcase
  endfunction

  task automatic launch(input logic [31:0] nb, input logic se, input logic [31:0] tg);
    @(negedge clk);
    wq_addr.delete();
    wq_data.delete();
    nonce_base = nb; search_en = se; target = tg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_we_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rd_addr[k] = mem_addr;
      rd_we_seen = rd_we_seen | mem_we;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = done;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL reset_done: got %b expected 1", done); end
    tests++; if (found !== 1'b0) begin fails++; $display("FAIL reset_found: got %b expected 0", found); end
    tests++; if (found_nonce !== 32'd0) begin fails++; $display("FAIL reset_found_nonce: got %h expected 0", found_nonce); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    tests++; if (mem_addr !== 16'd0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    tests++; if (mem_write_data !== 32'd0) begin fails++; $display("FAIL reset_wdata: got %h expected 0", mem_write_data); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dump;
    bit ok;
    logic [15:0] ga;
    logic [31:0] gd;
    launch(32'd0, 1'b0, 32'd0);
    for (int k = 0; k < 20; k++) begin
      tests++; if (rd_addr[k] !== MSG + 16'(k)) begin fails++; $display("FAIL dump_read_addr[%0d]: got %h expected %h", k, rd_addr[k], MSG + 16'(k)); end
    end
    tests++; if (rd_we_seen !== 1'b0) begin fails++; $display("FAIL dump_read_we: got %b expected 0", rd_we_seen); end
    wait_done(5000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL dump_timeout: done=%b expected 1", done); end
    tests++; if (wq_addr.size() != 16) begin fails++; $display("FAIL dump_write_count: got %0d expected 16", wq_addr.size()); end
    for (int k = 0; k < 16; k++) begin
      ga = (k < wq_addr.size()) ? wq_addr[k] : 16'hxxxx;
      gd = (k < wq_data.size()) ? wq_data[k] : 32'hxxxx_xxxx;
      tests++; if (ga !== OUT + 16'(k) || gd !== golden_h0(32'(k))) begin
        fails++; $display("FAIL dump_write[%0d]: got %h<-%h expected %h<-%h", k, ga, gd, OUT + 16'(k), golden_h0(32'(k)));
      end
    end
    tests++; if (found !== 1'b0) begin fails++; $display("FAIL dump_found: got %b expected 0", found); end
  endtask

  task automatic test_search_hit;
    bit ok, ef;
    logic [31:0] en, eh, h;
    ef = 1'b0; en = 32'd0; eh = 32'd0;
    for (int k = 0; k < 16; k++) begin
      h = golden_h0(32'h100 + 32'(k));
      if (!ef && h < 32'hFFFF_FFFF) begin ef = 1'b1; en = 32'h100 + 32'(k); eh = h; end
    end
    launch(32'h100, 1'b1, 32'hFFFF_FFFF);
    wait_done(5000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL hit_timeout: done=%b expected 1", done); end
    tests++; if (found !== ef) begin fails++; $display("FAIL hit_found: got %b expected %b", found, ef); end
    tests++; if (found_nonce !== en) begin fails++; $display("FAIL hit_nonce: got %h expected %h", found_nonce, en); end
    tests++; if (wq_addr.size() != 2) begin fails++; $display("FAIL hit_write_count: got %0d expected 2", wq_addr.size()); end
    if (wq_addr.size() >= 2) begin
      tests++; if (wq_addr[0] !== OUT || wq_data[0] !== en) begin fails++; $display("FAIL hit_write0: got %h<-%h expected %h<-%h", wq_addr[0], wq_data[0], OUT, en); end
      tests++; if (wq_addr[1] !== OUT + 16'd1 || wq_data[1] !== eh) begin fails++; $display("FAIL hit_write1: got %h<-%h expected %h<-%h", wq_addr[1], wq_data[1], OUT + 16'd1, eh); end
    end
  endtask

  task automatic test_search_miss;
    bit ok;
    launch(32'h200, 1'b1, 32'd0);
    wait_done(5000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL miss_timeout: done=%b expected 1", done); end
    tests++; if (found !== 1'b0) begin fails++; $display("FAIL miss_found: got %b expected 0", found); end
    tests++; if (wq_addr.size() != 2) begin fails++; $display("FAIL miss_write_count: got %0d expected 2", wq_addr.size()); end
    if (wq_addr.size() >= 2) begin
      tests++; if (wq_addr[0] !== OUT || wq_data[0] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL miss_write0: got %h<-%h expected %h<-ffffffff", wq_addr[0], wq_data[0], OUT); end
      tests++; if (wq_addr[1] !== OUT + 16'd1 || wq_data[1] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL miss_write1: got %h<-%h expected %h<-ffffffff", wq_addr[1], wq_data[1], OUT + 16'd1); end
    end
  endtask

  task automatic test_nonce_wrap;
    bit ok;
    logic [31:0] gd;
    launch(32'hFFFF_FFF8, 1'b0, 32'd0);
    wait_done(5000, ok);
    tests++; if (!ok || wq_addr.size() != 16) begin fails++; $display("FAIL wrap_count: got %0d writes done=%b expected 16 writes", wq_addr.size(), done); end
    for (int k = 0; k < 16; k++) begin
      gd = (k < wq_data.size()) ? wq_data[k] : 32'hxxxx_xxxx;
      tests++; if (gd !== golden_h0(32'hFFFF_FFF8 + 32'(k))) begin
        fails++; $display("FAIL wrap_write[%0d]: got %h expected %h", k, gd, golden_h0(32'hFFFF_FFF8 + 32'(k)));
      end
    end
  endtask

  task automatic test_start_ignored;
    bit ok;
    logic [31:0] gd;
    launch(32'd0, 1'b0, 32'd0);
    repeat (80) @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL ignore_busy: got done=%b expected 0", done); end
    nonce_base = 32'h5555; search_en = 1'b1; target = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000, ok);
    tests++; if (!ok || wq_addr.size() != 16) begin fails++; $display("FAIL ignore_count: got %0d writes expected 16", wq_addr.size()); end
    for (int k = 0; k < 16; k++) begin
      gd = (k < wq_data.size()) ? wq_data[k] : 32'hxxxx_xxxx;
      tests++; if (gd !== golden_h0(32'(k))) begin fails++; $display("FAIL ignore_write[%0d]: got %h expected %h", k, gd, golden_h0(32'(k))); end
    end
  endtask

  task automatic test_reset_midrun;
    int n = 0;
    int held;
    launch(32'd0, 1'b0, 32'd0);
    while (wq_addr.size() < 10 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    tests++; if (wq_addr.size() != 10 || mem_we !== 1'b1) begin fails++; $display("FAIL midrun_position: got %0d writes we=%b expected 10 writes we=1", wq_addr.size(), mem_we); end
    reset_n = 1'b0;
    #1;
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL midrun_we: got %b expected 0", mem_we); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL midrun_done: got %b expected 1", done); end
    tests++; if (found !== 1'b0) begin fails++; $display("FAIL midrun_found: got %b expected 0", found); end
    held = wq_addr.size();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (wq_addr.size() != held) begin fails++; $display("FAIL midrun_no_writes: got %0d writes expected %0d", wq_addr.size(), held); end
  endtask

  task automatic test_restart;
    bit ok;
    logic [31:0] h;
    h = golden_h0(32'h300);
    launch(32'h300, 1'b1, 32'hFFFF_FFFF);
    wait_done(5000, ok);
    tests++; if (!ok || found !== (h < 32'hFFFF_FFFF)) begin fails++; $display("FAIL restart_found: got %b done=%b expected %b", found, done, h < 32'hFFFF_FFFF); end
    tests++; if (found_nonce !== 32'h300) begin fails++; $display("FAIL restart_nonce: got %h expected 00000300", found_nonce); end
    tests++; if (wq_data.size() != 2 || wq_data[1] !== h) begin fails++; $display("FAIL restart_h0: got %0d writes expected 2 with H0 %h", wq_data.size(), h); end
  endtask

  task automatic test_param_sweep;
    int n = 0;
    @(negedge clk);
    sw_clr = 1'b1;
    nonce_base = 32'h40; search_en = 1'b0; target = 32'd0;
    @(negedge clk);
    sw_clr = 1'b0; sw_start = 1'b1;
    @(negedge clk);
    sw_start = 1'b0;
    while (sw_done != 3'b111 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    tests++; if (sw_done !== 3'b111) begin fails++; $display("FAIL sweep_timeout: got done %b expected 111", sw_done); end
    for (int g = 0; g < 3; g++) begin
      tests++; if (sw_wr(g) != 16) begin fails++; $display("FAIL sweep_count[cores=%0d]: got %0d expected 16", SW_NC[g], sw_wr(g)); end
      for (int k = 0; k < 16; k++) begin
        tests++; if (sw_img(g, k) !== golden_h0(32'h40 + 32'(k))) begin
          fails++; $display("FAIL sweep_image[cores=%0d][%0d]: got %h expected %h", SW_NC[g], k, sw_img(g, k), golden_h0(32'h40 + 32'(k)));
        end
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0; start = 1'b0; sw_start = 1'b0; sw_clr = 1'b0;
    message_addr = MSG; output_addr = OUT;
    nonce_base = 32'd0; search_en = 1'b0; target = 32'd0; rd_we_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      hdr_w[k] = 32'h0200_0000 ^ (32'(k) * 32'h9E37_79B9);
      mem[32'(MSG) + k] = hdr_w[k];
    end
    test_reset;
    test_dump;
    test_search_hit;
    test_search_miss;
    test_nonce_wrap;
    test_start_ignored;
    test_reset_midrun;
    test_restart;
    test_param_sweep;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
